// File: rtl/rv32_bus_arbiter.sv
// Two-master round-robin arbiter for the shared rv32 peripheral/RAM bus.
// Single-cycle address phase, bounded locked ownership, 1-cycle read return routing.
module rv32_bus_arbiter #(
    parameter int unsigned address_width = 32,
    parameter int unsigned data_width    = 32,
    parameter logic [address_width-1:0] ParkAddress = address_width'(32'hFFFF_FFFC),
    parameter int unsigned LockMaxCycles = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     m0_req_i,
    input  logic                     m0_we_i,
    input  logic [3:0]               m0_be_i,
    input  logic                     m0_lock_i,
    input  logic [address_width-1:0] m0_address_i,
    input  logic [data_width-1:0]    m0_data_i,
    output logic                     m0_gnt_o,
    output logic                     m0_rvalid_o,
    output logic [data_width-1:0]    m0_data_o,
    input  logic                     m1_req_i,
    input  logic                     m1_we_i,
    input  logic [3:0]               m1_be_i,
    input  logic                     m1_lock_i,
    input  logic [address_width-1:0] m1_address_i,
    input  logic [data_width-1:0]    m1_data_i,
    output logic                     m1_gnt_o,
    output logic                     m1_rvalid_o,
    output logic [data_width-1:0]    m1_data_o,
    output logic [address_width-1:0] address_o,
    output logic [data_width-1:0]    data_o,
    output logic                     we_o,
    output logic [3:0]               we_ram_o,
    input  logic [data_width-1:0]    data_i,
    output logic                     lock_timeout_o
);

    localparam int unsigned CntW = $clog2(LockMaxCycles + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic [CntW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [CntW-1:0]   lock_cnt_inc;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_owner_q, rd_owner_d;
    logic              timeout_q, timeout_d;
    logic              gnt0, gnt1;
    logic [3:0]        be_sel;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            timeout_q  <= timeout_d;
        end
    end

    assign lock_cnt_inc = (lock_cnt_q == CntW'(LockMaxCycles)) ? lock_cnt_q
                                                               : lock_cnt_q + CntW'(1);

    // Arbitration, lock FSM and slave-side mux
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        rd_owner_d = rd_owner_q;
        timeout_d  = 1'b0;
        gnt0       = 1'b0;
        gnt1       = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_req_i && m1_req_i) begin
                    gnt0 = last_q;
                    gnt1 = !last_q;
                end else begin
                    gnt0 = m0_req_i;
                    gnt1 = m1_req_i;
                end
                lock_cnt_d = '0;
                if (gnt0 && m0_lock_i) begin
                    state_d    = OWN0;
                    lock_cnt_d = CntW'(1);
                end else if (gnt1 && m1_lock_i) begin
                    state_d    = OWN1;
                    lock_cnt_d = CntW'(1);
                end
            end
            OWN0: begin
                gnt0       = m0_req_i;
                lock_cnt_d = lock_cnt_inc;
                if (!m0_lock_i) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q >= CntW'(LockMaxCycles - 1)) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                    timeout_d  = 1'b1;
                    last_d     = 1'b0;
                end
            end
            OWN1: begin
                gnt1       = m1_req_i;
                lock_cnt_d = lock_cnt_inc;
                if (!m1_lock_i) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q >= CntW'(LockMaxCycles - 1)) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                    timeout_d  = 1'b1;
                    last_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Grants must drop the moment reset asserts, even with requests held
        if (!reset_ni) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end

        if (gnt0) begin
            last_d     = 1'b0;
            rd_owner_d = 1'b0;
        end else if (gnt1) begin
            last_d     = 1'b1;
            rd_owner_d = 1'b1;
        end
        rd_pend_d = (gnt0 && !m0_we_i) || (gnt1 && !m1_we_i);

        address_o = ParkAddress;
        data_o    = '0;
        we_o      = 1'b0;
        be_sel    = '0;
        if (gnt0) begin
            address_o = m0_address_i;
            data_o    = m0_data_i;
            we_o      = m0_we_i;
            be_sel    = m0_be_i;
        end else if (gnt1) begin
            address_o = m1_address_i;
            data_o    = m1_data_i;
            we_o      = m1_we_i;
            be_sel    = m1_be_i;
        end
        we_ram_o = be_sel & {4{we_o}};
    end

    assign m0_gnt_o       = gnt0;
    assign m1_gnt_o       = gnt1;
    assign lock_timeout_o = timeout_q;

    // Read data goes only to the master that issued the read one cycle earlier
    assign m0_rvalid_o = rd_pend_q && !rd_owner_q;
    assign m1_rvalid_o = rd_pend_q && rd_owner_q;
    assign m0_data_o   = m0_rvalid_o ? data_i : '0;
    assign m1_data_o   = m1_rvalid_o ? data_i : '0;

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Scoreboard bench for rv32_bus_arbiter: grant/mux checks each cycle, read returns
// queued at grant time and compared when rvalid is due.
module tb_rv32_bus_arbiter;

    localparam logic [31:0] Park = 32'hFFFF_FFFC;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b1;
    logic        m0_req_i = 0, m0_we_i = 0, m0_lock_i = 0;
    logic [3:0]  m0_be_i = 0;
    logic [31:0] m0_address_i = 0, m0_data_i = 0;
    logic        m1_req_i = 0, m1_we_i = 0, m1_lock_i = 0;
    logic [3:0]  m1_be_i = 0;
    logic [31:0] m1_address_i = 0, m1_data_i = 0;
    logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [31:0] m0_data_o, m1_data_o;
    logic [31:0] address_o, data_o;
    logic        we_o, lock_timeout_o;
    logic [3:0]  we_ram_o;
    logic [31:0] data_i = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } ret_t;

    ret_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    rv32_bus_arbiter #(
        .address_width(32),
        .data_width   (32),
        .ParkAddress  (Park),
        .LockMaxCycles(4)
    ) dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .m0_req_i      (m0_req_i),
        .m0_we_i       (m0_we_i),
        .m0_be_i       (m0_be_i),
        .m0_lock_i     (m0_lock_i),
        .m0_address_i  (m0_address_i),
        .m0_data_i     (m0_data_i),
        .m0_gnt_o      (m0_gnt_o),
        .m0_rvalid_o   (m0_rvalid_o),
        .m0_data_o     (m0_data_o),
        .m1_req_i      (m1_req_i),
        .m1_we_i       (m1_we_i),
        .m1_be_i       (m1_be_i),
        .m1_lock_i     (m1_lock_i),
        .m1_address_i  (m1_address_i),
        .m1_data_i     (m1_data_i),
        .m1_gnt_o      (m1_gnt_o),
        .m1_rvalid_o   (m1_rvalid_o),
        .m1_data_o     (m1_data_o),
        .address_o     (address_o),
        .data_o        (data_o),
        .we_o          (we_o),
        .we_ram_o      (we_ram_o),
        .data_i        (data_i),
        .lock_timeout_o(lock_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(input int m, input logic req, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        if (m == 0) begin
            m0_req_i = req; m0_we_i = we; m0_lock_i = lock;
            m0_address_i = addr; m0_data_i = wdata; m0_be_i = be;
        end else begin
            m1_req_i = req; m1_we_i = we; m1_lock_i = lock;
            m1_address_i = addr; m1_data_i = wdata; m1_be_i = be;
        end
    endtask

    // One bus cycle: check due read return, grants, slave side; rnext is data_i next cycle
    task automatic step(input string tag, input logic eg0, input logic eg1, input logic eto,
                        input logic [31:0] rnext);
        ret_t        r;
        logic        ev0, ev1, ew;
        logic [31:0] ed0, ed1, ea, ed;
        logic [3:0]  ebe;
        @(negedge clk_i);
        ev0 = 0; ev1 = 0; ed0 = 0; ed1 = 0;
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            if (r.id) begin ev1 = 1; ed1 = r.data; end
            else      begin ev0 = 1; ed0 = r.data; end
        end
        check_eq({tag, ".rvalid0"}, 64'(m0_rvalid_o), 64'(ev0));
        check_eq({tag, ".rdata0"},  64'(m0_data_o),   64'(ed0));
        check_eq({tag, ".rvalid1"}, 64'(m1_rvalid_o), 64'(ev1));
        check_eq({tag, ".rdata1"},  64'(m1_data_o),   64'(ed1));
        check_eq({tag, ".gnt0"},    64'(m0_gnt_o),    64'(eg0));
        check_eq({tag, ".gnt1"},    64'(m1_gnt_o),    64'(eg1));
        check_eq({tag, ".timeout"}, 64'(lock_timeout_o), 64'(eto));
        ea = Park; ed = 0; ew = 0; ebe = 0;
        if (eg0) begin
            ea = m0_address_i; ed = m0_data_i; ew = m0_we_i; ebe = m0_we_i ? m0_be_i : 4'b0;
            if (!m0_we_i) begin r = '{id: 1'b0, data: rnext}; sb_q.push_back(r); end
        end else if (eg1) begin
            ea = m1_address_i; ed = m1_data_i; ew = m1_we_i; ebe = m1_we_i ? m1_be_i : 4'b0;
            if (!m1_we_i) begin r = '{id: 1'b1, data: rnext}; sb_q.push_back(r); end
        end
        check_eq({tag, ".addr"},  64'(address_o), 64'(ea));
        check_eq({tag, ".wdata"}, 64'(data_o),    64'(ed));
        check_eq({tag, ".we"},    64'(we_o),      64'(ew));
        check_eq({tag, ".weram"}, 64'(we_ram_o),  64'(ebe));
        @(posedge clk_i);
        #1;
        data_i = rnext;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".gnt0"},    64'(m0_gnt_o),       64'(0));
        check_eq({tag, ".gnt1"},    64'(m1_gnt_o),       64'(0));
        check_eq({tag, ".rvalid0"}, 64'(m0_rvalid_o),    64'(0));
        check_eq({tag, ".rvalid1"}, 64'(m1_rvalid_o),    64'(0));
        check_eq({tag, ".rdata0"},  64'(m0_data_o),      64'(0));
        check_eq({tag, ".addr"},    64'(address_o),      64'(Park));
        check_eq({tag, ".wdata"},   64'(data_o),         64'(0));
        check_eq({tag, ".we"},      64'(we_o),           64'(0));
        check_eq({tag, ".weram"},   64'(we_ram_o),       64'(0));
        check_eq({tag, ".timeout"}, 64'(lock_timeout_o), 64'(0));
    endtask

    initial begin
        #1 reset_ni = 1'b0;
        #2 check_reset_outputs("rst");
        repeat (2) @(posedge clk_i);
        #1 reset_ni = 1'b1;
        step("idle", 0, 0, 0, 32'h0);

        // Continuous contention: m0 first after reset, then alternating
        drive(0, 1, 0, 0, 32'h0000_0100, 32'h0, 4'hF);
        drive(1, 1, 0, 0, 32'h0000_0200, 32'h0, 4'hF);
        step("alt0", 1, 0, 0, 32'hA0A0_0001);
        drive(0, 1, 0, 0, 32'h0000_0104, 32'h0, 4'hF);
        step("alt1", 0, 1, 0, 32'hDEAD_BEEF);
        drive(1, 1, 0, 0, 32'h0000_0204, 32'h0, 4'hF);
        step("alt2", 1, 0, 0, 32'h0000_1234);
        step("alt3", 0, 1, 0, 32'hDEAD_BEEF);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        drive(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        step("alt_drain", 0, 0, 0, 32'h0);

        // Write from m1: strobes same cycle, no read return
        drive(1, 1, 1, 0, 32'h0000_1000, 32'h1234_5678, 4'b0011);
        step("wr", 0, 1, 0, 32'h5555_5555);
        drive(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        step("wr_after", 0, 0, 0, 32'h0);

        // m0 locks; m1 blocked until the first IDLE cycle after the lock drops
        drive(0, 1, 0, 1, 32'h0000_0300, 32'h0, 4'hF);
        drive(1, 1, 0, 0, 32'h0000_0400, 32'h0, 4'hF);
        step("lk0", 1, 0, 0, 32'h1111_0000);
        drive(0, 0, 0, 1, 32'h0, 32'h0, 4'h0);
        step("lk1", 0, 0, 0, 32'h2222_0000);
        drive(0, 1, 0, 0, 32'h0000_0304, 32'h0, 4'hF);
        step("lk2", 1, 0, 0, 32'h3333_0000);
        step("lk3", 0, 1, 0, 32'h4444_0000);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        drive(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        step("lk_drain", 0, 0, 0, 32'h0);

        // m1 holds lock past the 4-cycle bound
        drive(1, 1, 0, 1, 32'h0000_0500, 32'h0, 4'hF);
        step("to0", 0, 1, 0, 32'h5000_0000);
        drive(0, 1, 0, 0, 32'h0000_0600, 32'h0, 4'hF);
        step("to1", 0, 1, 0, 32'h5000_0001);
        step("to2", 0, 1, 0, 32'h5000_0002);
        step("to3", 0, 1, 0, 32'h5000_0003);
        step("to4", 1, 0, 1, 32'h5000_0004);
        drive(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        step("to5", 1, 0, 0, 32'h5000_0005);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        step("to_drain", 0, 0, 0, 32'h0);

        // Reset between a read grant and its return
        drive(0, 1, 0, 0, 32'h0000_0700, 32'h0, 4'hF);
        @(negedge clk_i);
        check_eq("mrst.gnt0_pre", 64'(m0_gnt_o), 64'(1));
        #2 reset_ni = 1'b0;
        #1 check_reset_outputs("mrst");
        @(posedge clk_i);
        #1 data_i = 32'hBAD0_BAD0;
        drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk_i);
        check_eq("mrst.rvalid0_post", 64'(m0_rvalid_o), 64'(0));
        check_eq("mrst.rvalid1_post", 64'(m1_rvalid_o), 64'(0));
        @(posedge clk_i);
        #1 reset_ni = 1'b1;
        step("post_rst", 0, 0, 0, 32'h0);
        drive(0, 1, 0, 0, 32'h0000_0800, 32'h0, 4'hF);
        drive(1, 1, 0, 0, 32'h0000_0900, 32'h0, 4'hF);
        step("post_rst_arb", 1, 0, 0, 32'h7777_0000);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        drive(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        step("final_drain", 0, 0, 0, 32'h0);

        check_eq("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
